prog_mem: RTL and testbench
===========================

# prog_mem

Program memory responder for the 4-bit microprocessor. It holds a 16×4 instruction/data store that is filled through a ready/valid loader port. Once filled, it answers the processor's fetches by returning the nibble addressed by the program counter on the data-memory bus. It sits between the test or loader logic and the processor's DM input and PC output. It also gates processor execution through `RUN_o`.

## Interface
Parameters:
- `AW`, 4: address width; depth is 2^AW words.
- `DW`, 4: word width.
- `NOP`, 4'b0000: value returned for out-of-range fetches and while not running.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `rst_i`, in, 1: reset. Synchronous and active-low.
- `LD_i`, in, 1: start or restart a program load.
- `WV_i`, in, 1: loader write-valid.
- `WD_i`, in, DW: loader write data.
- `END_i`, in, 1: loader end-of-program.
- `WR_o`, out, 1: loader write-ready.
- `PC_i`, in, AW: fetch address from the processor program counter.
- `DM_o`, out, DW: fetched word to the processor DM input.
- `RUN_o`, out, 1: program valid; the processor may execute. The processor's own reset is driven by the inverse of `RUN_o`.
- `CNT_o`, out, AW+1: number of words loaded, 0..2^AW.
- `ERR_o`, out, 1: sticky flag, set on a fetch at or beyond `CNT_o`.

## Operation
- Storage is a `2^AW × DW` register array. Memory contents are not cleared by reset; `CNT_o` masks stale words.
- State `IDLE` (reset state):
  - `WR_o`=0, `RUN_o`=0, `DM_o`=NOP.
  - `LD_i`=1 → `LOAD`. This clears the write address `wa`, `CNT_o` and `ERR_o`.
- State `LOAD`:
  - `WR_o`=1.
  - Each cycle with `WV_i`&`WR_o`: `mem[wa]`←`WD_i`, then `wa`+1 and `CNT_o`+1.
  - `END_i`=1 → `RUN` if the resulting count is ≥1, else → `IDLE`. A write in the same cycle as `END_i` is accepted and counted.
  - Writing the 2^AW-th word → `RUN` automatically, regardless of `END_i`. `wa` never wraps and no further write is accepted.
  - `LD_i` is ignored in `LOAD`.
- State `RUN`:
  - `RUN_o`=1, `WR_o`=0.
  - Each cycle, `DM_o`←`mem[PC_i]` if `PC_i` < `CNT_o`.
  - Otherwise `DM_o`←NOP and `ERR_o`←1. `ERR_o` stays set until the next `LD_i` or reset.
  - `WV_i` is ignored.
  - `LD_i`=1 → `LOAD`. This clears `wa`, `CNT_o` and `ERR_o`. `RUN_o` falls the next cycle and `DM_o` returns to NOP.
- Count arithmetic: `CNT_o` is AW+1 bits wide so a full load reads 16. The `PC_i` < `CNT_o` comparison is unsigned and zero-extends `PC_i`.

## Timing
- Reset: on a rising edge with `rst_i`=0, all of the following take effect at that edge:
  - state=`IDLE`, `wa`=0, `CNT_o`=0, `ERR_o`=0, `DM_o`=NOP, `WR_o`=0, `RUN_o`=0.
- Reset has priority over every other input, including mid-load and mid-run. A partial load is discarded; `CNT_o`=0.
- All outputs are registered.
- `WR_o` rises one cycle after `LD_i` is sampled in `IDLE` or `RUN`.
- `WR_o` falls in the cycle after the terminating write or `END_i`.
- Handshake: a write transfers on a rising edge where `WV_i` and `WR_o` are both 1. The loader may hold `WV_i` high for back-to-back writes, one word per cycle.
- `RUN_o` rises one cycle after `LOAD` exits.
- Fetch latency is one cycle. `PC_i` sampled at edge n is reflected on `DM_o` after edge n. `ERR_o` updates at the same edge.
- The first valid fetch is the edge after `RUN_o` rises. `DM_o` stays NOP until then.

## Test plan
- Reset then load: assert `rst_i`=0 for one edge, then release. Expect all outputs 0 / NOP. Pulse `LD_i`, write 4'h1, 4'h2, 4'h4 back-to-back, with `END_i` on the third write. Expect `CNT_o`=3, then `RUN_o`=1.
- Fetch: after the load above, drive `PC_i`=0,1,2. Expect `DM_o`=1,2,4 each one cycle later, with `ERR_o`=0.
- Out-of-range fetch: drive `PC_i`=3. Expect `DM_o`=0 and `ERR_o`=1. Then drive `PC_i`=0. Expect `DM_o`=1 while `ERR_o` remains 1.
- Full load: write 16 words 0..F with `END_i` held 0. Expect auto-exit, `CNT_o`=16, `RUN_o`=1. `PC_i`=F → `DM_o`=F.
- Empty load and reload:
  - `LD_i`, then `END_i` with no write → `IDLE`, `RUN_o`=0, `CNT_o`=0.
  - `LD_i` during `RUN` → `RUN_o` falls, `ERR_o` and `CNT_o` clear, `WR_o`=1.
- Reset mid-load: after 2 writes, assert `rst_i`=0. Expect `CNT_o`=0, `WR_o`=0 and state `IDLE` at that edge. Subsequent `WV_i` writes are ignored.

Source files
------------

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem
// Purpose  : Program memory responder for the 4-bit microprocessor. A
//            2^AW x DW register store is filled through a ready/valid loader
//            port, then answers program-counter fetches on the DM bus.
//            RUN_o gates processor execution (processor reset = ~RUN_o).
// Ports    : clk    - rising-edge clock
//            rst_i  - synchronous active-low reset
//            LD_i   - start / restart a program load
//            WV_i   - loader write-valid
//            WD_i   - loader write data (DW)
//            END_i  - loader end-of-program
//            WR_o   - loader write-ready
//            PC_i   - fetch address from processor PC (AW)
//            DM_o   - fetched word (DW), NOP when not running / out of range
//            RUN_o  - program valid, processor may execute
//            CNT_o  - number of words loaded, 0..2^AW (AW+1)
//            ERR_o  - sticky out-of-range fetch flag
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem #(
  parameter int              AW  = 4,
  parameter int              DW  = 4,
  parameter logic [DW-1:0]   NOP = '0
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          LD_i,
  input  logic          WV_i,
  input  logic [DW-1:0] WD_i,
  input  logic          END_i,
  output logic          WR_o,
  input  logic [AW-1:0] PC_i,
  output logic [DW-1:0] DM_o,
  output logic          RUN_o,
  output logic [AW:0]   CNT_o,
  output logic          ERR_o
);

  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW:0]   cnt_q,   cnt_d;
  logic          err_q,   err_d;
  logic [DW-1:0] dm_q,    dm_d;
  logic          wr_q;
  logic          run_q;
  logic          we;

  // Contents survive reset on purpose; cnt_q masks stale words.
  logic [DW-1:0] mem_q [DEPTH];

  // The write address always equals the running count during a load, so the
  // low AW bits of cnt_q serve as the write pointer. It never wraps because
  // the last slot forces the exit to RUN.
  logic [AW-1:0] wa;
  assign wa = cnt_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    dm_d    = NOP;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (LD_i) begin
          state_d = LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (WV_i && wr_q) begin
          we    = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
        end
        // Filling the final slot ends the load regardless of END_i.
        if (we && (cnt_q == CNT_LAST)) begin
          state_d = RUN;
        end else if (END_i) begin
          // cnt_d already includes a write accepted in this same cycle.
          state_d = (cnt_d != '0) ? RUN : IDLE;
        end
      end
      RUN: begin
        if (LD_i) begin
          state_d = LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if ({1'b0, PC_i} < cnt_q) begin
          dm_d = mem_q[PC_i];
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dm_q    <= NOP;
      wr_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dm_q    <= dm_d;
      // Flag registers mirror the next state so they line up with state_q.
      wr_q    <= (state_d == LOAD);
      run_q   <= (state_d == RUN);
    end
  end

  // Reset must also block a write that coincides with it.
  always_ff @(posedge clk) begin
    if (rst_i && we) begin
      mem_q[wa] <= WD_i;
    end
  end

  assign WR_o  = wr_q;
  assign RUN_o = run_q;
  assign DM_o  = dm_q;
  assign CNT_o = cnt_q;
  assign ERR_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem
// Purpose  : Self-checking bench for prog_mem. Directed scenarios followed by
//            randomized loads/fetches checked against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_mem;

  logic       clk;
  logic       rst_i;
  logic       LD_i;
  logic       WV_i;
  logic [3:0] WD_i;
  logic       END_i;
  logic       WR_o;
  logic [3:0] PC_i;
  logic [3:0] DM_o;
  logic       RUN_o;
  logic [4:0] CNT_o;
  logic       ERR_o;

  int n_cmp;
  int n_err;

  // Reference model: loaded words, count of valid words, sticky error.
  logic [3:0] model_mem [16];
  int         model_cnt;
  bit         model_err;

  prog_mem #(.AW(4), .DW(4), .NOP(4'b0000)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .LD_i  (LD_i),
    .WV_i  (WV_i),
    .WD_i  (WD_i),
    .END_i (END_i),
    .WR_o  (WR_o),
    .PC_i  (PC_i),
    .DM_o  (DM_o),
    .RUN_o (RUN_o),
    .CNT_o (CNT_o),
    .ERR_o (ERR_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Advance one rising edge and settle; outputs read after this reflect it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    if (WR_o !== 1'b0)  begin n_err++; $display("FAIL rst_wr: got %b want 0", WR_o); end
    n_cmp++;
    if (RUN_o !== 1'b0) begin n_err++; $display("FAIL rst_run: got %b want 0", RUN_o); end
    n_cmp++;
    if (DM_o !== 4'h0)  begin n_err++; $display("FAIL rst_dm: got %h want 0", DM_o); end
    n_cmp++;
    if (CNT_o !== 5'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", CNT_o); end
    n_cmp++;
    if (ERR_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", ERR_o); end
    n_cmp++;
    tick();
    if (WR_o !== 1'b0)  begin n_err++; $display("FAIL idle_wr: got %b want 0", WR_o); end
    n_cmp++;
  endtask

  task automatic test_load_fetch();
    logic [3:0] words [3];
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h4;
    LD_i = 1'b1;
    tick();
    LD_i = 1'b0;
    if (WR_o !== 1'b1) begin n_err++; $display("FAIL lf_wr_rise: got %b want 1", WR_o); end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      WV_i  = 1'b1;
      WD_i  = words[i];
      END_i = (i == 2);
      tick();
    end
    WV_i = 1'b0; END_i = 1'b0;
    if (CNT_o !== 5'd3) begin n_err++; $display("FAIL lf_cnt: got %0d want 3", CNT_o); end
    n_cmp++;
    if (RUN_o !== 1'b1) begin n_err++; $display("FAIL lf_run: got %b want 1", RUN_o); end
    n_cmp++;
    if (WR_o !== 1'b0)  begin n_err++; $display("FAIL lf_wr_fall: got %b want 0", WR_o); end
    n_cmp++;
    if (DM_o !== 4'h0)  begin n_err++; $display("FAIL lf_dm_nop: got %h want 0", DM_o); end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      PC_i = 4'(i);
      tick();
      if (DM_o !== words[i]) begin n_err++; $display("FAIL fetch_dm pc=%0d: got %h want %h", i, DM_o, words[i]); end
      n_cmp++;
      if (ERR_o !== 1'b0) begin n_err++; $display("FAIL fetch_err pc=%0d: got %b want 0", i, ERR_o); end
      n_cmp++;
    end
  endtask

  task automatic test_out_of_range();
    PC_i = 4'd3;
    tick();
    if (DM_o !== 4'h0)  begin n_err++; $display("FAIL oor_dm: got %h want 0", DM_o); end
    n_cmp++;
    if (ERR_o !== 1'b1) begin n_err++; $display("FAIL oor_err: got %b want 1", ERR_o); end
    n_cmp++;
    PC_i = 4'd0;
    tick();
    if (DM_o !== 4'h1)  begin n_err++; $display("FAIL oor_back_dm: got %h want 1", DM_o); end
    n_cmp++;
    if (ERR_o !== 1'b1) begin n_err++; $display("FAIL oor_sticky: got %b want 1", ERR_o); end
    n_cmp++;
  endtask

  task automatic test_full_load();
    LD_i = 1'b1;
    tick();
    LD_i = 1'b0;
    if (RUN_o !== 1'b0) begin n_err++; $display("FAIL full_run_fall: got %b want 0", RUN_o); end
    n_cmp++;
    if (ERR_o !== 1'b0) begin n_err++; $display("FAIL full_err_clr: got %b want 0", ERR_o); end
    n_cmp++;
    if (DM_o !== 4'h0)  begin n_err++; $display("FAIL full_dm_nop: got %h want 0", DM_o); end
    n_cmp++;
    for (int i = 0; i < 16; i++) begin
      WV_i = 1'b1;
      WD_i = 4'(i);
      tick();
    end
    // Keep offering a word: it must not be accepted once full.
    WD_i = 4'h9;
    if (CNT_o !== 5'd16) begin n_err++; $display("FAIL full_cnt: got %0d want 16", CNT_o); end
    n_cmp++;
    if (RUN_o !== 1'b1)  begin n_err++; $display("FAIL full_run: got %b want 1", RUN_o); end
    n_cmp++;
    if (WR_o !== 1'b0)   begin n_err++; $display("FAIL full_wr: got %b want 0", WR_o); end
    n_cmp++;
    PC_i = 4'hF;
    tick();
    WV_i = 1'b0;
    if (DM_o !== 4'hF)   begin n_err++; $display("FAIL full_dmF: got %h want f", DM_o); end
    n_cmp++;
    if (CNT_o !== 5'd16) begin n_err++; $display("FAIL full_cnt_hold: got %0d want 16", CNT_o); end
    n_cmp++;
    PC_i = 4'h0;
    tick();
    if (DM_o !== 4'h0 || ERR_o !== 1'b0) begin
      n_err++; $display("FAIL full_dm0: got dm=%h err=%b want dm=0 err=0", DM_o, ERR_o);
    end
    n_cmp++;
  endtask

  task automatic test_empty_reload();
    LD_i = 1'b1;
    tick();
    LD_i = 1'b0;
    END_i = 1'b1;
    tick();
    END_i = 1'b0;
    if (RUN_o !== 1'b0 || CNT_o !== 5'd0 || WR_o !== 1'b0) begin
      n_err++; $display("FAIL empty: got run=%b cnt=%0d wr=%b want 0 0 0", RUN_o, CNT_o, WR_o);
    end
    n_cmp++;
    // One-word program, then force an error, then reload from RUN.
    LD_i = 1'b1;
    tick();
    LD_i = 1'b0;
    WV_i = 1'b1; WD_i = 4'hA; END_i = 1'b1;
    tick();
    WV_i = 1'b0; END_i = 1'b0;
    if (RUN_o !== 1'b1 || CNT_o !== 5'd1) begin
      n_err++; $display("FAIL one_word: got run=%b cnt=%0d want 1 1", RUN_o, CNT_o);
    end
    n_cmp++;
    PC_i = 4'd1;
    tick();
    if (ERR_o !== 1'b1) begin n_err++; $display("FAIL one_word_err: got %b want 1", ERR_o); end
    n_cmp++;
    LD_i = 1'b1;
    tick();
    LD_i = 1'b0;
    if (RUN_o !== 1'b0 || ERR_o !== 1'b0 || CNT_o !== 5'd0 || WR_o !== 1'b1 || DM_o !== 4'h0) begin
      n_err++; $display("FAIL reload: got run=%b err=%b cnt=%0d wr=%b dm=%h want 0 0 0 1 0",
                        RUN_o, ERR_o, CNT_o, WR_o, DM_o);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_load();
    // Currently in LOAD from the previous reload.
    WV_i = 1'b1;
    WD_i = 4'h3;
    tick();
    tick();
    if (CNT_o !== 5'd2) begin n_err++; $display("FAIL mid_pre_cnt: got %0d want 2", CNT_o); end
    n_cmp++;
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    if (CNT_o !== 5'd0 || WR_o !== 1'b0 || RUN_o !== 1'b0) begin
      n_err++; $display("FAIL mid_rst: got cnt=%0d wr=%b run=%b want 0 0 0", CNT_o, WR_o, RUN_o);
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) tick();
    WV_i = 1'b0;
    if (CNT_o !== 5'd0 || WR_o !== 1'b0) begin
      n_err++; $display("FAIL mid_ignore: got cnt=%0d wr=%b want 0 0", CNT_o, WR_o);
    end
    n_cmp++;
  endtask

  // Random loads of random length with random idle gaps, then random fetches.
  task automatic test_random();
    int  len;
    int  idx;
    bit  end_with_write;
    int  pc;
    logic [3:0] exp_dm;
    for (int it = 0; it < 24; it++) begin
      len = int'($urandom_range(1, 16));
      end_with_write = 1'($urandom_range(0, 1));
      LD_i = 1'b1;
      tick();
      LD_i = 1'b0;
      model_cnt = 0;
      model_err = 1'b0;
      idx = 0;
      while (idx < len) begin
        if ($urandom_range(0, 3) == 0) begin
          WV_i = 1'b0; END_i = 1'b0; WD_i = 4'($urandom);
          tick();
        end else begin
          WV_i  = 1'b1;
          WD_i  = 4'($urandom);
          END_i = (idx == len - 1) && (len < 16) && end_with_write;
          model_mem[idx] = WD_i;
          tick();
          idx++;
          model_cnt = idx;
        end
      end
      WV_i = 1'b0;
      if (len < 16 && !end_with_write) begin
        END_i = 1'b1;
        tick();
      end
      END_i = 1'b0;
      if (RUN_o !== 1'b1 || CNT_o !== 5'(model_cnt)) begin
        n_err++; $display("FAIL rnd_load it=%0d: got run=%b cnt=%0d want 1 %0d", it, RUN_o, CNT_o, model_cnt);
      end
      n_cmp++;
      for (int f = 0; f < 8; f++) begin
        pc = int'($urandom_range(0, 15));
        PC_i = 4'(pc);
        WV_i = 1'($urandom_range(0, 1));
        tick();
        if (pc < model_cnt) exp_dm = model_mem[pc];
        else begin exp_dm = 4'h0; model_err = 1'b1; end
        if (DM_o !== exp_dm || ERR_o !== model_err) begin
          n_err++; $display("FAIL rnd_fetch it=%0d pc=%0d: got dm=%h err=%b want dm=%h err=%b",
                            it, pc, DM_o, ERR_o, exp_dm, model_err);
        end
        n_cmp++;
      end
      WV_i = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_i = 1'b1;
    LD_i  = 1'b0;
    WV_i  = 1'b0;
    WD_i  = 4'h0;
    END_i = 1'b0;
    PC_i  = 4'h0;
    tick();
    test_reset();
    test_load_fetch();
    test_out_of_range();
    test_full_load();
    test_empty_reload();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
